// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// register selects, segment lookup table and the byte-lane merge helper.
package seg7_scan_ctrl_pkg;

    localparam int BUS_ADDR_W = 12;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_CTRL   = 2'd1,
        REG_DPMASK = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    localparam int CTRL_LZB_BIT = 16;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {DP,G,F,E,D,C,B,A}; entry 0 sits in the lowest byte, DP bit kept off.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [BUS_DATA_W-1:0] byte_merge(
        input logic [BUS_DATA_W-1:0] old_val,
        input logic [BUS_DATA_W-1:0] new_val,
        input logic [3:0]            be
    );
        logic [BUS_DATA_W-1:0] r;
        r = old_val;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = new_val[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Register bus between the bridge's 7-seg channel and the scan controller.
interface seg7_scan_ctrl_if;
    import seg7_scan_ctrl_pkg::*;

    logic [BUS_ADDR_W-1:0] addr;
    logic [3:0]            we;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_DATA_W-1:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);

endinterface

// File: rtl/seg7_decode.sv
// Hex nibble to active-low 7-segment pattern (decimal point handled by the caller).
module seg7_decode
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[hex][6:0];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Bus-mapped multiplexed 7-segment controller: DATA/CTRL/DPMASK registers,
// per-slot blank window, digit mask, decimal points and leading-zero blanking.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 25000,
    parameter int BLANK_CYCLES = 500
)
(
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_ctrl_if.slave       bus,
    output logic [NUM_DIGITS-1:0] led_en,
    output logic [7:0]            led
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [31:0] DIGIT_MASK = (32'h1 << NUM_DIGITS) - 32'h1;
    localparam logic [31:0] DATA_MASK  = (NUM_DIGITS == 8) ? 32'hFFFF_FFFF
                                                           : ((32'h1 << (4 * NUM_DIGITS)) - 32'h1);
    localparam logic [31:0] CTRL_MASK  = DIGIT_MASK | (32'h1 << CTRL_LZB_BIT);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [31:0]      data_reg;
    logic [31:0]      ctrl_reg;
    logic [31:0]      dp_reg;
    logic [PRE_W-1:0] presc;
    logic [IDX_W-1:0] idx;
    reg_sel_e         sel;
    logic             unused_addr_bits;

    assign sel              = reg_sel_e'(bus.addr[3:2]);
    assign unused_addr_bits = ^{bus.addr[11:4], bus.addr[1:0]};

    // Unimplemented bits are masked off on write so they always read back as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            ctrl_reg <= DIGIT_MASK;
            dp_reg   <= '0;
        end else if (|bus.we) begin
            case (sel)
                REG_DATA:   data_reg <= byte_merge(data_reg, bus.wdata, bus.we) & DATA_MASK;
                REG_CTRL:   ctrl_reg <= byte_merge(ctrl_reg, bus.wdata, bus.we) & CTRL_MASK;
                REG_DPMASK: dp_reg   <= byte_merge(dp_reg, bus.wdata, bus.we) & DIGIT_MASK;
                default:    ;
            endcase
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (sel)
            REG_DATA:   bus.rdata = data_reg;
            REG_CTRL:   bus.rdata = ctrl_reg;
            REG_DPMASK: bus.rdata = dp_reg;
            default:    bus.rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRE_LAST) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    logic [31:0]           tail;
    logic [6:0]            seg_bits;
    logic                  digit_off;
    logic [NUM_DIGITS-1:0] digit_sel;

    // tail holds the current nibble and every more-significant one; all-zero means a leading zero.
    assign tail      = data_reg >> {idx, 2'b00};
    assign digit_sel = ~(NUM_DIGITS'(1) << idx);
    assign digit_off = (presc < BLANK_END)
                    || !ctrl_reg[idx]
                    || (ctrl_reg[CTRL_LZB_BIT] && (idx != '0) && (tail == 32'd0));

    seg7_decode u_decode (
        .hex (tail[3:0]),
        .seg (seg_bits)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_en <= '1;
            led    <= SEG_OFF;
        end else if (digit_off) begin
            led_en <= '1;
            led    <= SEG_OFF;
        end else begin
            led_en <= digit_sel;
            led    <= {~dp_reg[idx], seg_bits};
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: a time-indexed behavioural model
// predicts every output cycle, plus hand-computed literal checks.
module tb_seg7_scan_ctrl;

    localparam int ND = 8;
    localparam int SD = 4;
    localparam int BC = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  led_en;
    logic [7:0]  led;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .led_en (led_en),
        .led    (led)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Reference state: registers plus the count of clock edges since reset release.
    logic [31:0] m_data = 32'h0;
    logic [31:0] m_ctrl = 32'hFF;
    logic [31:0] m_dp   = 32'h0;
    int          t      = 0;
    logic [7:0]  exp_led_en = 8'hFF;
    logic [7:0]  exp_led    = 8'hFF;

    int          mp, mi;
    logic [31:0] upper, tmp;
    logic [3:0]  nib;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [11:0] a);
        case (a[3:2])
            2'd0:    return m_data;
            2'd1:    return m_ctrl;
            2'd2:    return m_dp;
            default: return 32'h0;
        endcase
    endfunction

    // Outputs registered at edge t reflect slot position t and the registers before that edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data     = 32'h0;
            m_ctrl     = 32'hFF;
            m_dp       = 32'h0;
            t          = 0;
            exp_led_en = 8'hFF;
            exp_led    = 8'hFF;
        end else begin
            mp = t % SD;
            mi = (t / SD) % ND;
            exp_led_en = 8'hFF;
            exp_led    = 8'hFF;
            if (mp >= BC) begin
                upper = m_data >> (4 * mi);
                nib   = upper[3:0];
                if (m_ctrl[mi] && !(m_ctrl[16] && mi > 0 && upper == 32'h0)) begin
                    exp_led_en = 8'hFF ^ (8'h01 << mi);
                    exp_led    = {~m_dp[mi], seg_tab[nib][6:0]};
                end
            end
            if (bus.we != 4'h0 && bus.addr[3:2] != 2'd3) begin
                tmp = modelRead(bus.addr);
                for (int k = 0; k < 4; k++)
                    if (bus.we[k]) tmp[8*k +: 8] = bus.wdata[8*k +: 8];
                case (bus.addr[3:2])
                    2'd0:    m_data = tmp;
                    2'd1:    m_ctrl = tmp & 32'h0001_00FF;
                    default: m_dp   = tmp & 32'h0000_00FF;
                endcase
            end
            t++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checkOutput("model led_en", {24'h0, led_en}, {24'h0, exp_led_en});
            checkOutput("model led", {24'h0, led}, {24'h0, exp_led});
        end
    end

    task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = be;
        @(negedge clk);
        bus.we    = 4'h0;
    endtask

    task automatic readReg(input string name, input logic [11:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus.addr = a;
        bus.we   = 4'h0;
        #1;
        checkOutput(name, bus.rdata, exp);
    endtask

    task automatic waitLit(input int digit, output bit ok);
        logic [7:0] want;
        want = 8'hFF ^ (8'h01 << digit);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (led_en == want) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL waitLit: digit %0d not lit within 40 cycles, led_en=%h", digit, led_en);
        end
    endtask

    task automatic litCheck(input string name, input int digit, input logic [7:0] exp_seg);
        bit ok;
        waitLit(digit, ok);
        if (ok) checkOutput(name, {24'h0, led}, {24'h0, exp_seg});
    endtask

    task automatic waitRise0(output int n);
        bit prev, cur;
        prev = 1'b1;
        n = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            n++;
            cur = (led_en == 8'hFE);
            if (cur && !prev) break;
            prev = cur;
        end
    endtask

    task automatic frameCount(input logic [7:0] forbidden, output int hits);
        hits = 0;
        for (int c = 0; c < ND * SD; c++) begin
            @(negedge clk);
            if ((~led_en & forbidden) != 8'h0) hits++;
        end
    endtask

    initial begin
        int n;
        int hits;
        bit ok;
        logic [31:0] rmask;

        bus.addr  = 12'h0;
        bus.we    = 4'h0;
        bus.wdata = 32'h0;

        // Reset values
        #2 rst = 1'b1;
        started = 1'b1;
        #1;
        checkOutput("reset led_en", {24'h0, led_en}, 32'hFF);
        checkOutput("reset led", {24'h0, led}, 32'hFF);
        bus.addr = 12'h004;
        #1 checkOutput("reset ctrl", bus.rdata, 32'h0000_00FF);
        bus.addr = 12'h000;
        #1 checkOutput("reset data", bus.rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic scan
        applyStimulus(12'h000, 32'h7654_3210, 4'hF);
        litCheck("digit0 seg", 0, 8'hC0);
        litCheck("digit3 seg", 3, 8'hB0);
        litCheck("digit7 seg", 7, 8'hF8);
        waitRise0(n);
        waitRise0(n);
        checkOutput("frame period", n, 32);

        // Byte enables
        applyStimulus(12'h000, 32'hAABB_CCDD, 4'b0100);
        readReg("byte lane data", 12'h000, 32'h76BB_3210);
        litCheck("digit4 after lane", 4, 8'h83);

        // Leading-zero blanking
        applyStimulus(12'h000, 32'h0000_0A05, 4'hF);
        applyStimulus(12'h004, 32'h0001_00FF, 4'hF);
        litCheck("lzb digit2", 2, 8'h88);
        litCheck("lzb digit0", 0, 8'h92);
        frameCount(8'hF8, hits);
        checkOutput("lzb high digits lit", hits, 0);
        applyStimulus(12'h000, 32'h0, 4'hF);
        litCheck("lzb zero digit0", 0, 8'hC0);
        frameCount(8'hFE, hits);
        checkOutput("lzb zero others lit", hits, 0);

        // Mask and decimal point
        applyStimulus(12'h004, 32'h0000_00F0, 4'hF);
        applyStimulus(12'h008, 32'h0000_0010, 4'hF);
        litCheck("dp digit4", 4, 8'h40);
        litCheck("nodp digit5", 5, 8'hC0);
        frameCount(8'h0F, hits);
        checkOutput("masked digits lit", hits, 0);

        // Async reset while digit 5 is lit
        waitLit(5, ok);
        #2 rst = 1'b1;
        #1;
        checkOutput("midslot rst led_en", {24'h0, led_en}, 32'hFF);
        checkOutput("midslot rst led", {24'h0, led}, 32'hFF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 checkOutput("post rst blank", {24'h0, led_en}, 32'hFF);
        @(posedge clk);
        #1;
        checkOutput("post rst led_en", {24'h0, led_en}, 32'hFE);
        checkOutput("post rst led", {24'h0, led}, 32'hC0);

        // Reserved slot
        applyStimulus(12'h00C, 32'hFFFF_FFFF, 4'hF);
        readReg("reserved read", 12'h00C, 32'h0);
        readReg("data after rsvd", 12'h002, 32'h0);
        readReg("ctrl after rsvd", 12'h004, 32'h0000_00FF);
        readReg("dp after rsvd", 12'h008, 32'h0);

        // Randomised register traffic against the model
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            case ($urandom_range(0, 2))
                0:       rmask = 32'hFFFF_FFFF;
                1:       rmask = 32'h0000_FFFF;
                default: rmask = 32'h0000_000F;
            endcase
            bus.addr  = 12'($urandom);
            bus.wdata = $urandom & rmask;
            bus.we    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            #1 checkOutput("rand rdata", bus.rdata, modelRead(bus.addr));
            if (it == 200) begin
                #2 rst = 1'b1;
                #1 checkOutput("rand rst led", {24'h0, led}, 32'hFF);
                @(negedge clk);
                rst = 1'b0;
            end
        end
        @(negedge clk);
        bus.we = 4'h0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised, bus-mapped multiplexed 7-segment display controller.
- Sits behind the Bridge's 7-seg channel in the miniRV SoC, on the same clk and rst as the bridge interface.
- Adds over the current display driver:
  - configurable digit count and scan rate
  - byte-enable register writes and readback
  - per-digit enable mask, decimal-point mask, leading-zero blanking
  - an anti-ghosting blank window per digit slot

Parameters:
NUM_DIGITS, 8, digits driven (1..8); DATA holds NUM_DIGITS hex nibbles
SCAN_DIV, 25000, clk cycles per digit slot (>=2)
BLANK_CYCLES, 500, cycles at the start of each slot with all segments off (0..SCAN_DIV-1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
addr  in  12  byte offset within the peripheral window
we  in  4  per-byte write enables; 4'b0000 = no write
wdata  in  32  write data
rdata  out  32  combinational register readback
led_en  out  NUM_DIGITS  digit selects, active-low
led  out  8  segments, active-low, bit order {DP,G,F,E,D,C,B,A}

Behaviour:
- Register map (addr[3:2]; addr[1:0] ignored):
  - 0 DATA: nibble i drives digit i.
  - 1 CTRL: [NUM_DIGITS-1:0] digit enable mask; bit16 = LZB (leading-zero blank).
  - 2 DPMASK: [NUM_DIGITS-1:0] decimal point on.
  - 3: reserved; writes ignored, reads 0.
- Writes: byte lane k is updated on the rising clk when we[k]=1. Bits beyond the implemented width are dropped and read back as 0.
- rdata: combinational function of addr and the current registers; no latency.
- Reset (async, immediate):
  - DATA=0, CTRL mask=all ones, LZB=0, DPMASK=0
  - prescaler=0, digit index=0
  - led_en=all ones, led=8'hFF
- Prescaler:
  - counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the index advances (NUM_DIGITS-1 -> 0).
- Outputs are registered. Each cycle they are computed from the *current* prescaler, index and registers, so the outputs lag by exactly 1 cycle.
  - Blank window (prescaler < BLANK_CYCLES): led_en=all ones, led=8'hFF.
  - Digit disabled (mask bit 0, or LZB-blanked): led_en=all ones, led=8'hFF.
  - Otherwise: led_en bit[index]=0 and all other bits 1; led = decode(nibble[index]) with DP bit7 = ~DPMASK[index].
- Decode (active-low, DP excluded):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E
- LZB: digit i (i>0) is blanked when LZB=1 and nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never LZB-blanked.
- Write during a slot: the new value is visible on led 1 cycle after the write edge. The scan phase is not disturbed.
- NUM_DIGITS=1: the index stays 0; the prescaler still runs for the blank window.
- Reset mid-slot: outputs go blank immediately and scanning restarts at digit 0 after release.

Decomposition:
- Shared package:
  - register offsets (REG_DATA, REG_CTRL, REG_DPMASK)
  - CTRL_LZB_BIT=16
  - 16-entry segment LUT constants
  - SEG_OFF=8'hFF
- One sub-module, seg7_decode: 4-bit hex -> 7-bit active-low segments (combinational).

Test Plan:
1. Reset (NUM_DIGITS=8, SCAN_DIV=4, BLANK_CYCLES=1).
   - Stimulus: assert rst.
   - Required: led_en=8'hFF and led=8'hFF immediately; rdata at CTRL = 0x000000FF.
2. Scan: write DATA=0x76543210 with we=4'hF.
   - Each slot: 1 blank cycle, then 3 cycles with led_en=~(1<<i).
   - Digit 0 shows C0, digit 1 shows F9, ..., digit 7 shows F8.
   - Index wraps 7 -> 0 after 32 cycles.
3. Byte enables: DATA=0x76543210, then write wdata=0xAABBCCDD with we=4'b0100.
   - Required: DATA reads 0x76BB3210; digit 4 shows 83 (B).
4. LZB: DATA=0x00000A05, CTRL=0x000100FF.
   - Digits 0..2 show 92, C0, 88; digits 3..7 stay blank.
   - DATA=0 with LZB on: only digit 0 shows C0.
5. Mask and DP: CTRL=0x000000F0, DPMASK=0x10.
   - Digits 0..3 blank.
   - Digit 4 shows decode with bit7=0 (e.g. 0x40 for nibble 0).
   - Digits 5..7 show DP off.
6. Async reset mid-slot while digit 5 is lit.
   - Outputs go FF immediately.
   - After release, the first lit digit is 0 after BLANK_CYCLES+1 cycles.
   - Reserved addr 0xC: read = 0 and writes are ignored.
